// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters
// and a registered decode of sync, blanking and frame markers.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int PIX_DIV   = 1,
    parameter int CW        = 11
) (
    input  logic          CLK_40M,
    input  logic          RESET,
    input  logic          ENABLE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          ACTIVE,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          PIX_CE,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_CNT =
        ((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) - 1;
    localparam int DW =
        (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    // Counters must hold the largest coordinate; divider must be >= 1.
    generate
        if (PIX_DIV < 1 || (2 ** CW) <= MAX_CNT) begin : g_bad_params
            $error("vga_timing_gen: CW too small or PIX_DIV < 1");
        end
    endgenerate

    logic [DW-1:0] div;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          ce;
    logic [31:0]   hx;
    logic [31:0]   vx;
    logic          act_d;
    logic          hs_d;
    logic          vs_d;
    logic          ls_d;
    logic          fs_d;

    assign ce = ENABLE && (div == DIV_LAST);
    assign hx = 32'(h);
    assign vx = 32'(v);

    // Pixel-rate divider; pauses in place while ENABLE is low.
    always_ff @(posedge CLK_40M) begin
        if (RESET) begin
            div <= '0;
        end else if (ENABLE) begin
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    // Raster position: column advances per pixel, line per wrap.
    always_ff @(posedge CLK_40M) begin
        if (RESET) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v <= '0;
                end else begin
                    v <= v + CW'(1);
                end
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    // Decode of the current (pre-advance) position.
    always_comb begin
        act_d = 1'b0;
        hs_d  = ~HS_ON;
        vs_d  = ~VS_ON;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (hx < H_ACT_END && vx < V_ACT_END) begin
            act_d = 1'b1;
        end
        if (hx >= HS_BEG && hx < HS_END) begin
            hs_d = HS_ON;
        end
        if (vx >= VS_BEG && vx < VS_END) begin
            vs_d = VS_ON;
        end
        if (ce && h == '0) begin
            ls_d = 1'b1;
            fs_d = (v == '0);
        end
    end

    // Output register: strobes follow ce, levels freeze while paused.
    always_ff @(posedge CLK_40M) begin
        if (RESET) begin
            X           <= '0;
            Y           <= '0;
            ACTIVE      <= 1'b0;
            HSYNC       <= ~HS_ON;
            VSYNC       <= ~VS_ON;
            PIX_CE      <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            PIX_CE      <= ce;
            LINE_START  <= ls_d;
            FRAME_START <= fs_d;
            if (ENABLE) begin
                X      <= h;
                Y      <= v;
                ACTIVE <= act_d;
                HSYNC  <= hs_d;
                VSYNC  <= vs_d;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a tiny 16x8 raster,
// with a PIX_DIV=2 positive-sync unit and a PIX_DIV=1 negative one.
module tb_vga_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = 16;
    localparam int VT = 8;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b1;
    logic a_en  = 1'b1;
    logic b_rst = 1'b1;
    logic b_en  = 1'b1;

    logic       a_hs, a_vs, a_act, a_ce, a_ls, a_fs;
    logic [3:0] a_x, a_y;
    logic       b_hs, b_vs, b_act, b_ce, b_ls, b_fs;
    logic [3:0] b_x, b_y;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .PIX_DIV(2), .CW(4)
    ) dut_a (
        .CLK_40M(clk), .RESET(a_rst), .ENABLE(a_en),
        .HSYNC(a_hs), .VSYNC(a_vs), .ACTIVE(a_act),
        .X(a_x), .Y(a_y), .PIX_CE(a_ce),
        .LINE_START(a_ls), .FRAME_START(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIX_DIV(1), .CW(4)
    ) dut_b (
        .CLK_40M(clk), .RESET(b_rst), .ENABLE(b_en),
        .HSYNC(b_hs), .VSYNC(b_vs), .ACTIVE(b_act),
        .X(b_x), .Y(b_y), .PIX_CE(b_ce),
        .LINE_START(b_ls), .FRAME_START(b_fs)
    );

    pix_t exp_q[$];
    pix_t e_pix;
    pix_t m_pix;
    logic m_ce;
    bit   sel = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    assign m_ce  = sel ? b_ce : a_ce;
    assign m_pix = sel ? pix_t'({b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs})
                       : pix_t'({a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs});

    function automatic pix_t model(int h, int v, bit hp, bit vp);
        pix_t p;
        p.x   = 4'(h);
        p.y   = 4'(v);
        p.act = (h < HA) && (v < VA);
        p.hs  = (h >= HA + HF && h < HA + HF + HS) ? hp : !hp;
        p.vs  = (v >= VA + VF && v < VA + VF + VS) ? vp : !vp;
        p.ls  = (h == 0);
        p.fs  = (h == 0) && (v == 0);
        return p;
    endfunction

    task automatic push_frames(input int n, input bit hp, input bit vp);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(i % HT, (i / HT) % VT, hp, vp));
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pix(input int x, input int y, input int budget,
                            input string name);
        int n = 0;
        while (!(a_ce && a_x == 4'(x) && a_y == 4'(y)) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: pixel (%0d,%0d) not seen in %0d clocks",
                     name, x, y, budget);
        end
    endtask

    task automatic wait_flag(input bit use_ls, input int budget,
                             input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(use_ls ? a_ls : a_ce) && n < budget);
        if (!(use_ls ? a_ls : a_ce)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: flag not seen in %0d clocks", name, budget);
        end
    endtask

    // Monitor: every presented pixel is matched against the scoreboard.
    always @(negedge clk) begin
        if (m_ce) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: pixel x=%0d y=%0d, expected none",
                         m_pix.x, m_pix.y);
            end else begin
                e_pix = exp_q.pop_front();
                if (m_pix !== e_pix) begin
                    n_errors++;
                    $display("FAIL sb_pixel: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                             m_pix.x, m_pix.y, m_pix.act, m_pix.hs,
                             m_pix.vs, m_pix.ls, m_pix.fs,
                             e_pix.x, e_pix.y, e_pix.act, e_pix.hs,
                             e_pix.vs, e_pix.ls, e_pix.fs);
                end
            end
        end
    end

    initial begin
        int  ls_t, fs_t, hs_run, hs_cnt, vs_cnt, act_cnt;
        int  ls_cnt, fs_cnt, low_cnt, px, py, n;
        bit  prev_hs, hs_on;

        // Unit A: reset for 3 clocks, then release with ENABLE high.
        repeat (3) tick();
        chk("a_rst_x", a_x, 0);
        chk("a_rst_y", a_y, 0);
        chk("a_rst_act", a_act, 0);
        chk("a_rst_hs", a_hs, 0);
        chk("a_rst_vs", a_vs, 0);
        chk("a_rst_ce", a_ce, 0);
        chk("a_rst_ls", a_ls, 0);
        chk("a_rst_fs", a_fs, 0);
        a_rst = 1'b0;
        push_frames(3 * HT * VT, 1'b1, 1'b1);
        tick();
        chk("a_rel1_ce", a_ce, 0);
        chk("a_rel1_fs", a_fs, 0);
        chk("a_rel1_hs", a_hs, 0);
        tick();
        chk("a_rel2_ce", a_ce, 1);
        chk("a_rel2_fs", a_fs, 1);
        chk("a_rel2_x", a_x, 0);
        chk("a_rel2_y", a_y, 0);
        chk("a_rel2_act", a_act, 1);

        // One free-running frame plus the next frame start.
        ls_t = -1; fs_t = -1; hs_run = 0; hs_cnt = 0; vs_cnt = 0;
        act_cnt = 0; ls_cnt = 0; fs_cnt = 0; px = -1; py = -1;
        prev_hs = 1'b0;
        for (int c = 2; c <= 258; c++) begin
            if (c > 2) tick();
            if (a_ls) begin
                if (ls_t >= 0) chk("a_ls_period", cyc - ls_t, 32);
                ls_t = cyc;
            end
            if (a_fs) begin
                if (fs_t >= 0) chk("a_fs_period", cyc - fs_t, 256);
                fs_t = cyc;
            end
            if (a_hs && !prev_hs) chk("a_hs_start_x", a_x, 10);
            if (a_hs) begin
                hs_run++;
            end else if (prev_hs) begin
                chk("a_hs_width", hs_run, 6);
                hs_run = 0;
            end
            prev_hs = a_hs;
            if (a_vs) chk("a_vs_line", int'(a_y == 5 || a_y == 6), 1);
            if (c < 258) begin
                if (a_hs) hs_cnt++;
                if (a_vs) vs_cnt++;
                if (a_act && a_ce) act_cnt++;
                if (a_ls) ls_cnt++;
                if (a_fs) fs_cnt++;
            end
            if (a_ce) begin
                if (px == 15 && py == 7) begin
                    chk("a_wrap_f_x", a_x, 0);
                    chk("a_wrap_f_y", a_y, 0);
                    chk("a_wrap_f_fs", a_fs, 1);
                end
                if (px == 15 && py == 3) begin
                    chk("a_wrap_l_x", a_x, 0);
                    chk("a_wrap_l_y", a_y, 4);
                    chk("a_wrap_l_ls", a_ls, 1);
                    chk("a_wrap_l_fs", a_fs, 0);
                end
                px = a_x;
                py = a_y;
            end
        end
        chk("a_fs_next_frame", a_fs, 1);
        chk("a_hs_clocks", hs_cnt, 48);
        chk("a_vs_clocks", vs_cnt, 64);
        chk("a_active_pix", act_cnt, 32);
        chk("a_ls_count", ls_cnt, 8);
        chk("a_fs_count", fs_cnt, 1);

        // Pause for 7 clocks right after pixel 5 is presented.
        wait_pix(5, 0, 40, "a_wait_x5");
        a_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("a_frz_ce", a_ce, 0);
            chk("a_frz_x", a_x, 5);
            chk("a_frz_y", a_y, 0);
            chk("a_frz_ls", a_ls, 0);
        end
        a_en = 1'b1;
        wait_flag(1'b0, 10, "a_resume", n);
        chk("a_resume_lat", n, 2);
        chk("a_resume_x", a_x, 6);
        wait_flag(1'b1, 60, "a_next_line", n);
        chk("a_ls_stretch", cyc - ls_t, 39);

        // One-clock reset in the middle of the frame.
        wait_pix(12, 2, 80, "a_wait_12_2");
        a_rst = 1'b1;
        exp_q.delete();
        push_frames(HT * VT, 1'b1, 1'b1);
        tick();
        a_rst = 1'b0;
        chk("a_mrst_x", a_x, 0);
        chk("a_mrst_y", a_y, 0);
        chk("a_mrst_act", a_act, 0);
        chk("a_mrst_hs", a_hs, 0);
        chk("a_mrst_vs", a_vs, 0);
        chk("a_mrst_ce", a_ce, 0);
        chk("a_mrst_ls", a_ls, 0);
        chk("a_mrst_fs", a_fs, 0);
        wait_flag(1'b0, 10, "a_post_rst", n);
        chk("a_post_rst_lat", n, 2);
        chk("a_post_rst_x", a_x, 0);
        chk("a_post_rst_y", a_y, 0);
        chk("a_post_rst_fs", a_fs, 1);
        repeat (20) tick();

        // Unit B: inverted syncs, one clock per pixel.
        exp_q.delete();
        sel = 1'b1;
        chk("b_rst_x", b_x, 0);
        chk("b_rst_act", b_act, 0);
        chk("b_rst_hs", b_hs, 1);
        chk("b_rst_vs", b_vs, 1);
        chk("b_rst_ce", b_ce, 0);
        chk("b_rst_fs", b_fs, 0);
        b_rst = 1'b0;
        push_frames(2 * HT * VT + 8, 1'b0, 1'b0);
        tick();
        chk("b_rel1_ce", b_ce, 1);
        chk("b_rel1_fs", b_fs, 1);
        chk("b_rel1_x", b_x, 0);
        chk("b_rel1_y", b_y, 0);
        chk("b_rel1_act", b_act, 1);

        ls_t = -1; fs_t = -1; hs_run = 0; hs_cnt = 0; vs_cnt = 0;
        act_cnt = 0; ls_cnt = 0; low_cnt = 0;
        prev_hs = 1'b0;
        for (int c = 1; c <= 129; c++) begin
            if (c > 1) tick();
            hs_on = !b_hs;
            if (b_ls) begin
                if (ls_t >= 0) chk("b_ls_period", cyc - ls_t, 16);
                ls_t = cyc;
            end
            if (b_fs) begin
                if (fs_t >= 0) chk("b_fs_period", cyc - fs_t, 128);
                fs_t = cyc;
            end
            if (hs_on && !prev_hs) chk("b_hs_start_x", b_x, 10);
            if (hs_on) begin
                hs_run++;
            end else if (prev_hs) begin
                chk("b_hs_width", hs_run, 3);
                hs_run = 0;
            end
            prev_hs = hs_on;
            if (c < 129) begin
                if (!b_ce) low_cnt++;
                if (hs_on) hs_cnt++;
                if (!b_vs) vs_cnt++;
                if (b_act && b_ce) act_cnt++;
                if (b_ls) ls_cnt++;
            end
        end
        chk("b_fs_next_frame", b_fs, 1);
        chk("b_ce_low_clocks", low_cnt, 0);
        chk("b_hs_clocks", hs_cnt, 24);
        chk("b_vs_clocks", vs_cnt, 32);
        chk("b_active_pix", act_cnt, 32);
        chk("b_ls_count", ls_cnt, 8);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
